// File: rtl/alu_sweep_driver.sv
// Self-test initiator for the 4-bit, 2-bit-opcode ALU: sweeps every (op, A, B)
// vector, holds it for SETTLE cycles, then samples and checks the ALU result.
module alu_sweep_driver #(
  parameter int SETTLE   = 2,
  parameter int OP_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [3:0]  alu_result,
  output logic        busy,
  output logic        done,
  output logic [10:0] err_count,
  output logic        fail_valid,
  output logic [9:0]  fail_vec,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [9:0] LAST_IDX    = 10'((OP_COUNT - 1) * 256 + 255);

  state_t      r_state, w_state;
  logic [9:0]  r_idx, w_idx;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [10:0] r_err, w_err;
  logic        r_fail_valid, w_fail_valid;
  logic [9:0]  r_fail_vec, w_fail_vec;

  logic [3:0]  w_expected;
  logic        w_mismatch;

  // Reference result for the vector currently on the ALU inputs.
  always_comb begin
    w_expected = 4'd0;
    case (r_idx[9:8])
      2'd0:    w_expected = r_idx[7:4] + r_idx[3:0];
      2'd1:    w_expected = r_idx[7:4] - r_idx[3:0];
      2'd2:    w_expected = r_idx[7:4] & r_idx[3:0];
      default: w_expected = r_idx[7:4] | r_idx[3:0];
    endcase
  end

  assign w_mismatch = (alu_result != w_expected);

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_busy       = r_busy;
    w_done       = r_done;
    w_err        = r_err;
    w_fail_valid = r_fail_valid;
    w_fail_vec   = r_fail_vec;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_idx        = 10'd0;
          w_cnt        = 4'd0;
          w_err        = 11'd0;
          w_fail_valid = 1'b0;
          w_fail_vec   = 10'd0;
          w_done       = 1'b0;
          w_busy       = 1'b1;
          w_state      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state = ST_SAMPLE;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (w_mismatch) begin
          w_err = r_err + 11'd1;
          if (!r_fail_valid) begin
            w_fail_valid = 1'b1;
            w_fail_vec   = r_idx;
          end
        end
        // The last vector stays on the ALU inputs after the sweep ends.
        if (r_idx == LAST_IDX) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = ST_DONE;
        end else begin
          w_idx   = r_idx + 10'd1;
          w_cnt   = 4'd0;
          w_state = ST_HOLD;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 10'd0;
      r_cnt        <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 11'd0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 10'd0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
      r_fail_valid <= w_fail_valid;
      r_fail_vec   <= w_fail_vec;
    end
  end

  assign alu_op     = r_idx[9:8];
  assign alu_a      = r_idx[7:4];
  assign alu_b      = r_idx[3:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;
  assign dbg_state  = r_state;

endmodule
